sprite_anim_color: RTL and testbench
====================================

// Module: sprite_anim_color
// PURPOSE
//  Parametrised, pipelined sprite pixel source with built-in animation sequencer.
//  - Compares the VGA scan position against a latched sprite box.
//  - Addresses one external frame-concatenated image ROM.
//  - Outputs a registered colour plus an opaque flag for the layer mixer.
//  - Steps animation frames on its own (static / loop / one-shot); top level no longer drives frame selects.
// PARAMETERS
//  WIDTH       112      sprite width in pixels
//  HEIGHT      72       sprite height in pixels
//  FRAMES      4        frames stored in ROM; frame f occupies words [f*WIDTH*HEIGHT, (f+1)*WIDTH*HEIGHT)
//  FRAME_W     2        frame index width; must be >= clog2(FRAMES)
//  ADDR_W      15       ROM address width; must be >= clog2(FRAMES*WIDTH*HEIGHT)
//  COLOR_W     16       pixel width
//  TRANSPARENT 16'hffff colour key; output when no sprite pixel is shown
//  HOLD_TICKS  8        frame_tick pulses per animation step, range 1..255
// PORTS
//  clk        in  1        pixel-domain clock
//  rst        in  1        asynchronous active-high reset
//  col        in  10       scan column from vgac
//  row        in  9        scan row from vgac
//  posx       in  10       sprite left edge; sampled only on frame_tick
//  posy       in  9        sprite top edge; sampled only on frame_tick
//  frame_tick in  1        1-cycle pulse, once per video frame at vblank start
//  anim_mode  in  2        00 static, 01 loop, 10 one-shot, 11 reserved (treated as static)
//  anim_base  in  FRAME_W  first frame of the sequence
//  anim_len   in  FRAME_W  sequence length minus 1
//  anim_start in  1        1-cycle pulse: (re)start the sequence at anim_base
//  rom_addr   out ADDR_W   registered address to the asynchronous-read image ROM
//  rom_data   in  COLOR_W  ROM word for rom_addr, same cycle
//  color      out COLOR_W  pixel colour
//  opaque     out 1        1 = sprite pixel present and != TRANSPARENT
//  cur_frame  out FRAME_W  frame index currently displayed
//  anim_done  out 1        one-shot finished; holds until next anim_start
// BEHAVIOUR
//  Reset values
//  - rom_addr=0, color=TRANSPARENT, opaque=0, cur_frame=0, anim_done=0.
//  - Latched box = (0,0). FSM = IDLE. Tick counter = 0.
//  Position latch
//  - px/py load from posx/posy on the frame_tick cycle only. A mid-frame posx change never tears the sprite.
//  Hit test
//  - col >= px && col < px+WIDTH && row >= py && row < py+HEIGHT.
//  - Sums are computed 1 bit wider (11 b / 10 b). No wrap-around; a box beyond col 1023 is clipped.
//  Pipeline, 2 cycles
//  - S1 registers hit1 and rom_addr = cur_frame*WIDTH*HEIGHT + (row-py)*WIDTH + (col-px).
//  - rom_addr holds its previous value when there is no hit.
//  - S2: color <= hit1 ? rom_data : TRANSPARENT; opaque <= hit1 && rom_data != TRANSPARENT.
//  - color and opaque are valid 2 clk after the col/row they belong to. Caller compensates with its own sync delay.
//  Animation FSM, states IDLE / RUN / DONE
//  - IDLE: cur_frame=anim_base, anim_done=0. Goes to RUN on anim_start when anim_mode is 01 or 10.
//  - RUN: each frame_tick increments the tick counter. When it reaches HOLD_TICKS it clears and the frame advances:
//    - cur_frame < anim_base+anim_len: cur_frame+1.
//    - Otherwise, loop mode: cur_frame=anim_base.
//    - Otherwise, one-shot mode: go to DONE with anim_done=1 and the last frame held.
//  - DONE: holds cur_frame. anim_start goes to RUN at anim_base with anim_done=0.
//  - anim_mode 00 or 11 in any state: go to IDLE next cycle.
//  - anim_start while in RUN: restart at anim_base, counter=0.
//  - anim_start and frame_tick in the same cycle: start wins; the tick is not counted.
//  - cur_frame changes only on frame_tick or start edges, so there is no intra-frame frame swap other than an explicit start.
//  - anim_base+anim_len >= FRAMES is a caller error; cur_frame saturates at FRAMES-1.
//  rst mid-line
//  - Outputs return to reset values immediately.
//  - The first valid colour appears 2 clk after rst deasserts. The latched box stays (0,0) until the next frame_tick.
// CONFIGURATION
//  SPRITE_HFLIP_EN defined
//  - Adds input port hflip (1 b), sampled on frame_tick with posx/posy.
//  - When 1, the column offset becomes WIDTH-1-(col-px).
//  - Latency is unchanged.
//  SPRITE_HFLIP_EN undefined
//  - No hflip port; the column offset is always col-px.
// TESTING
//  T1 reset: assert rst mid-scan -> color=16'hffff, opaque=0, cur_frame=0, rom_addr=0 the same cycle.
//  T2 latency/addr: posx=100, posy=50, tick, col=101,row=52 -> rom_addr=0*8064+2*112+1=225 after 1 clk; color=rom_data(225) after 2 clk.
//  T3 clipping: posx=1000, col=1023 -> hit, offset 23. col=5 -> TRANSPARENT, no wrap hit.
//  T4 loop: mode=01, base=0, len=3, HOLD_TICKS=2, start, 10 ticks -> cur_frame 0,0,1,1,2,2,3,3,0,0.
//  T5 one-shot: mode=10, base=1, len=1 -> frames 1,2 then DONE, anim_done=1, frame 2 held.
//     Then start+tick in the same cycle -> frame 1, counter 0, anim_done=0.
//  T6 tearing/flip: change posx mid-frame -> hit box unchanged until tick.
//     With SPRITE_HFLIP_EN, hflip=1, col=px -> offset 111.

Source files
------------

// File: rtl/sprite_anim_color.sv
// sprite_anim_color: two-stage sprite pixel source (box hit test, ROM addressing, colour key)
// with a built-in static/loop/one-shot frame sequencer. Define SPRITE_HFLIP_EN to add the hflip port.
module sprite_anim_color #(
    parameter int                 WIDTH       = 112,
    parameter int                 HEIGHT      = 72,
    parameter int                 FRAMES      = 4,
    parameter int                 FRAME_W     = 2,
    parameter int                 ADDR_W      = 15,
    parameter int                 COLOR_W     = 16,
    parameter logic [COLOR_W-1:0] TRANSPARENT = 16'hffff,
    parameter int                 HOLD_TICKS  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9:0]         col,
    input  logic [8:0]         row,
    input  logic [9:0]         posx,
    input  logic [8:0]         posy,
    input  logic               frame_tick,
`ifdef SPRITE_HFLIP_EN
    input  logic               hflip,
`endif
    input  logic [1:0]         anim_mode,
    input  logic [FRAME_W-1:0] anim_base,
    input  logic [FRAME_W-1:0] anim_len,
    input  logic               anim_start,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic [COLOR_W-1:0] color,
    output logic               opaque,
    output logic [FRAME_W-1:0] cur_frame,
    output logic               anim_done
);
    localparam logic [ADDR_W-1:0]  FRAME_WORDS = ADDR_W'(WIDTH * HEIGHT);
    localparam logic [ADDR_W-1:0]  LINE_WORDS  = ADDR_W'(WIDTH);
    localparam logic [10:0]        BOX_W       = 11'(WIDTH);
    localparam logic [9:0]         BOX_H       = 10'(HEIGHT);
    localparam logic [9:0]         FLIP_MAX    = 10'(WIDTH - 1);
    localparam logic [FRAME_W:0]   LAST_FRAME  = (FRAME_W + 1)'(FRAMES - 1);
    localparam logic [7:0]         HOLD_LAST   = 8'(HOLD_TICKS - 1);
    localparam logic [1:0]         MODE_LOOP   = 2'b01;
    localparam logic [1:0]         MODE_ONCE   = 2'b10;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    logic [9:0]         px_q, px_d;
    logic [8:0]         py_q, py_d;
    logic               hflip_q, hflip_d;
    logic               hit1_q, hit1_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               opaque_q, opaque_d;
    state_t             state_q, state_d;
    logic [FRAME_W-1:0] cur_frame_q, cur_frame_d;
    logic               anim_done_q, anim_done_d;
    logic [7:0]         tick_cnt_q, tick_cnt_d;

    logic [10:0]        x_end;
    logic [9:0]         y_end;
    logic               hit_s0;
    logic [9:0]         col_raw, col_off;
    logic [8:0]         row_off;
    logic [ADDR_W-1:0]  addr_s0;

    function automatic logic [FRAME_W-1:0] clamp_frame(input logic [FRAME_W:0] f);
        return (f > LAST_FRAME) ? LAST_FRAME[FRAME_W-1:0] : f[FRAME_W-1:0];
    endfunction

    // Box ends are one bit wider than the scan coordinates, so a box hanging past the
    // right/bottom edge is clipped instead of wrapping back to column/row 0.
    assign x_end   = {1'b0, px_q} + BOX_W;
    assign y_end   = {1'b0, py_q} + BOX_H;
    assign hit_s0  = (col >= px_q) && ({1'b0, col} < x_end) &&
                     (row >= py_q) && ({1'b0, row} < y_end);
    assign col_raw = col - px_q;
    assign row_off = row - py_q;
    assign col_off = hflip_q ? (FLIP_MAX - col_raw) : col_raw;
    assign addr_s0 = ADDR_W'(cur_frame_q) * FRAME_WORDS + ADDR_W'(row_off) * LINE_WORDS
                   + ADDR_W'(col_off);

    always_comb begin
        px_d    = px_q;
        py_d    = py_q;
        hflip_d = hflip_q;
        if (frame_tick) begin
            px_d = posx;
            py_d = posy;
`ifdef SPRITE_HFLIP_EN
            hflip_d = hflip;
`else
            hflip_d = 1'b0;
`endif
        end
        hit1_d     = hit_s0;
        rom_addr_d = hit_s0 ? addr_s0 : rom_addr_q;
        color_d    = hit1_q ? rom_data : TRANSPARENT;
        opaque_d   = hit1_q && (rom_data != TRANSPARENT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_q       <= '0;
            py_q       <= '0;
            hflip_q    <= 1'b0;
            hit1_q     <= 1'b0;
            rom_addr_q <= '0;
            color_q    <= TRANSPARENT;
            opaque_q   <= 1'b0;
        end else begin
            px_q       <= px_d;
            py_q       <= py_d;
            hflip_q    <= hflip_d;
            hit1_q     <= hit1_d;
            rom_addr_q <= rom_addr_d;
            color_q    <= color_d;
            opaque_q   <= opaque_d;
        end
    end

    logic [FRAME_W:0]   seq_last;
    logic [FRAME_W:0]   frame_inc;
    logic [FRAME_W-1:0] base_frame;
    logic               animated;

    assign seq_last   = {1'b0, anim_base} + {1'b0, anim_len};
    assign frame_inc  = {1'b0, cur_frame_q} + {{FRAME_W{1'b0}}, 1'b1};
    assign base_frame = clamp_frame({1'b0, anim_base});
    assign animated   = (anim_mode == MODE_LOOP) || (anim_mode == MODE_ONCE);

    // A start always wins over a simultaneous tick, and the frame only moves on tick/start.
    always_comb begin
        state_d     = state_q;
        cur_frame_d = cur_frame_q;
        anim_done_d = anim_done_q;
        tick_cnt_d  = tick_cnt_q;
        if (!animated) begin
            state_d     = IDLE;
            cur_frame_d = base_frame;
            anim_done_d = 1'b0;
            tick_cnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cur_frame_d = base_frame;
                    anim_done_d = 1'b0;
                    tick_cnt_d  = '0;
                    if (anim_start) state_d = RUN;
                end
                RUN: begin
                    if (anim_start) begin
                        cur_frame_d = base_frame;
                        anim_done_d = 1'b0;
                        tick_cnt_d  = '0;
                    end else if (frame_tick) begin
                        if (tick_cnt_q == HOLD_LAST) begin
                            tick_cnt_d = '0;
                            if ({1'b0, cur_frame_q} < seq_last) begin
                                cur_frame_d = clamp_frame(frame_inc);
                            end else if (anim_mode == MODE_LOOP) begin
                                cur_frame_d = base_frame;
                            end else begin
                                state_d     = DONE;
                                anim_done_d = 1'b1;
                            end
                        end else begin
                            tick_cnt_d = tick_cnt_q + 8'd1;
                        end
                    end
                end
                DONE: begin
                    if (anim_start) begin
                        state_d     = RUN;
                        cur_frame_d = base_frame;
                        anim_done_d = 1'b0;
                        tick_cnt_d  = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_frame_q <= '0;
            anim_done_q <= 1'b0;
            tick_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cur_frame_q <= cur_frame_d;
            anim_done_q <= anim_done_d;
            tick_cnt_q  <= tick_cnt_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign color     = color_q;
    assign opaque    = opaque_q;
    assign cur_frame = cur_frame_q;
    assign anim_done = anim_done_q;
endmodule

// File: tb/tb_sprite_anim_color.sv
// Self-checking bench for sprite_anim_color: directed scenarios plus randomized pixels and
// animation traffic, compared against a closed-form model of the sprite box and frame sequence.
module tb_sprite_anim_color;
    localparam int          WIDTH  = 112;
    localparam int          HEIGHT = 72;
    localparam int          HOLD   = 2;
    localparam logic [15:0] TRANSP = 16'hffff;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  col, posx;
    logic [8:0]  row, posy;
    logic        frame_tick, anim_start;
    logic [1:0]  anim_mode, anim_base, anim_len;
    logic [14:0] rom_addr;
    logic [15:0] rom_data, color;
    logic        opaque, anim_done;
    logic [1:0]  cur_frame;
`ifdef SPRITE_HFLIP_EN
    logic        hflip = 1'b0;
`endif

    logic [15:0] rom_mem [0:32767];
    assign rom_data = rom_mem[rom_addr];

    sprite_anim_color #(.HOLD_TICKS(HOLD)) dut (
        .clk(clk), .rst(rst), .col(col), .row(row), .posx(posx), .posy(posy),
        .frame_tick(frame_tick),
`ifdef SPRITE_HFLIP_EN
        .hflip(hflip),
`endif
        .anim_mode(anim_mode), .anim_base(anim_base), .anim_len(anim_len),
        .anim_start(anim_start), .rom_addr(rom_addr), .rom_data(rom_data),
        .color(color), .opaque(opaque), .cur_frame(cur_frame), .anim_done(anim_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: latched box, ticks counted since the last start, last hit address.
    int m_px, m_py, m_flip, m_ticks, m_active, m_last_addr;
    bit          e_hit;
    int          e_addr;
    logic [15:0] e_color;
    logic        e_opq;

    function automatic int exp_frame();
        int steps;
        if (m_active == 0) return int'(anim_base);
        steps = m_ticks / HOLD;
        if (anim_mode == 2'b01) return int'(anim_base) + steps % (int'(anim_len) + 1);
        if (steps > int'(anim_len)) return int'(anim_base) + int'(anim_len);
        return int'(anim_base) + steps;
    endfunction

    function automatic logic exp_done();
        return (m_active != 0) && (anim_mode == 2'b10) && ((m_ticks / HOLD) > int'(anim_len));
    endfunction

    function automatic logic [1:0] exp_frame2();
        int f;
        f = exp_frame();
        return f[1:0];
    endfunction

    task automatic model_reset();
        m_px = 0; m_py = 0; m_flip = 0; m_ticks = 0; m_active = 0; m_last_addr = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (frame_tick) begin
            m_px = int'(posx);
            m_py = int'(posy);
`ifdef SPRITE_HFLIP_EN
            m_flip = int'(hflip);
`endif
        end
        if (anim_mode == 2'b00 || anim_mode == 2'b11) begin
            m_active = 0; m_ticks = 0;
        end else if (anim_start) begin
            m_active = 1; m_ticks = 0;
        end else if (frame_tick && m_active != 0) begin
            m_ticks++;
        end
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
    endtask

    task automatic drive_pixel(input int c, input int r);
        int coff;
        col = 10'(c);
        row = 9'(r);
        e_hit = (c >= m_px) && (c < m_px + WIDTH) && (r >= m_py) && (r < m_py + HEIGHT);
        if (e_hit) begin
            coff = c - m_px;
            if (m_flip != 0) coff = WIDTH - 1 - coff;
            m_last_addr = exp_frame() * WIDTH * HEIGHT + (r - m_py) * WIDTH + coff;
        end
        e_addr  = m_last_addr;
        e_color = e_hit ? rom_mem[e_addr] : TRANSP;
        e_opq   = e_hit && (rom_mem[e_addr] != TRANSP);
        $display("pixel col=%0d row=%0d box=(%0d,%0d) hit=%0d addr=%0d", c, r, m_px, m_py, e_hit, e_addr);
        cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1; col = '0; row = '0; posx = '0; posy = '0; frame_tick = 1'b0;
        anim_mode = 2'b00; anim_base = 2'd0; anim_len = 2'd0; anim_start = 1'b0;
        #1;
        checks++; if (rom_addr !== 15'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", rom_addr); end
        checks++; if (color !== TRANSP) begin errors++; $display("FAIL reset_color: got %h expected %h", color, TRANSP); end
        checks++; if (opaque !== 1'b0) begin errors++; $display("FAIL reset_opaque: got %b expected 0", opaque); end
        checks++; if (cur_frame !== 2'd0) begin errors++; $display("FAIL reset_frame: got %0d expected 0", cur_frame); end
        checks++; if (anim_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", anim_done); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cycle();
        $display("test_reset done");
    endtask

    task automatic test_latency_addr();
        logic [15:0] p_color;
        logic        p_opq;
        posx = 10'd100; posy = 9'd50;
        tick();
        drive_pixel(101, 52);
        checks++; if (rom_addr !== 15'd225) begin errors++; $display("FAIL t2_addr_const: got %0d expected 225", rom_addr); end
        p_color = e_color; p_opq = e_opq;
        drive_pixel(103, 52);
        checks++; if (rom_addr !== 15'(e_addr)) begin errors++; $display("FAIL t2_addr2: got %0d expected %0d", rom_addr, e_addr); end
        checks++; if (color !== p_color) begin errors++; $display("FAIL t2_color1: got %h expected %h", color, p_color); end
        checks++; if (opaque !== p_opq) begin errors++; $display("FAIL t2_opaque1: got %b expected %b", opaque, p_opq); end
        p_color = e_color; p_opq = e_opq;
        cycle();
        checks++; if (color !== p_color) begin errors++; $display("FAIL t2_color2: got %h expected %h", color, p_color); end
        checks++; if (opaque !== p_opq) begin errors++; $display("FAIL t2_opaque2: got %b expected %b", opaque, p_opq); end
    endtask

    task automatic test_clipping();
        logic [15:0] p_color;
        posx = 10'd1000; posy = 9'd0;
        tick();
        drive_pixel(1023, 0);
        checks++; if (rom_addr !== 15'd23) begin errors++; $display("FAIL t3_edge_addr: got %0d expected 23", rom_addr); end
        p_color = e_color;
        drive_pixel(5, 0);
        checks++; if (rom_addr !== 15'd23) begin errors++; $display("FAIL t3_hold_addr: got %0d expected 23", rom_addr); end
        checks++; if (color !== p_color) begin errors++; $display("FAIL t3_edge_color: got %h expected %h", color, p_color); end
        cycle();
        checks++; if (color !== TRANSP) begin errors++; $display("FAIL t3_wrap_color: got %h expected %h", color, TRANSP); end
        checks++; if (opaque !== 1'b0) begin errors++; $display("FAIL t3_wrap_opaque: got %b expected 0", opaque); end
    endtask

    task automatic test_loop();
        int table_f [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        anim_mode = 2'b01; anim_base = 2'd0; anim_len = 2'd3; anim_start = 1'b1;
        cycle();
        anim_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            $display("loop step=%0d frame=%0d", i, cur_frame);
            checks++; if (int'(cur_frame) != table_f[i]) begin errors++; $display("FAIL t4_table[%0d]: got %0d expected %0d", i, cur_frame, table_f[i]); end
            checks++; if (cur_frame !== exp_frame2()) begin errors++; $display("FAIL t4_model[%0d]: got %0d expected %0d", i, cur_frame, exp_frame()); end
            tick();
            cycle();
        end
    endtask

    task automatic test_oneshot();
        anim_mode = 2'b10; anim_base = 2'd1; anim_len = 2'd1; anim_start = 1'b1;
        cycle();
        anim_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            $display("oneshot tick=%0d frame=%0d done=%b", i, cur_frame, anim_done);
            checks++; if (cur_frame !== exp_frame2()) begin errors++; $display("FAIL t5_frame[%0d]: got %0d expected %0d", i, cur_frame, exp_frame()); end
            checks++; if (anim_done !== exp_done()) begin errors++; $display("FAIL t5_done[%0d]: got %b expected %b", i, anim_done, exp_done()); end
        end
        checks++; if (cur_frame !== 2'd2 || anim_done !== 1'b1) begin errors++; $display("FAIL t5_held: got frame %0d done %b expected 2 1", cur_frame, anim_done); end
        anim_start = 1'b1; frame_tick = 1'b1;
        cycle();
        anim_start = 1'b0; frame_tick = 1'b0;
        checks++; if (cur_frame !== 2'd1 || anim_done !== 1'b0) begin errors++; $display("FAIL t5_restart: got frame %0d done %b expected 1 0", cur_frame, anim_done); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (cur_frame !== exp_frame2()) begin errors++; $display("FAIL t5_after_restart[%0d]: got %0d expected %0d", i, cur_frame, exp_frame()); end
        end
        anim_mode = 2'b00; anim_base = 2'd0;
        cycle();
    endtask

    task automatic test_tearing();
        posx = 10'd200; posy = 9'd100;
        tick();
        posx = 10'd400;
        drive_pixel(210, 110);
        checks++; if (rom_addr !== 15'(e_addr)) begin errors++; $display("FAIL t6_old_box: got %0d expected %0d", rom_addr, e_addr); end
        drive_pixel(410, 110);
        checks++; if (rom_addr !== 15'(e_addr)) begin errors++; $display("FAIL t6_no_new_box: got %0d expected %0d", rom_addr, e_addr); end
        cycle();
        checks++; if (color !== TRANSP) begin errors++; $display("FAIL t6_no_tear_color: got %h expected %h", color, TRANSP); end
        tick();
        drive_pixel(410, 110);
        checks++; if (rom_addr !== 15'(e_addr)) begin errors++; $display("FAIL t6_new_box: got %0d expected %0d", rom_addr, e_addr); end
`ifdef SPRITE_HFLIP_EN
        hflip = 1'b1;
        tick();
        hflip = 1'b0;
        drive_pixel(400, 100);
        checks++; if (rom_addr !== 15'd111) begin errors++; $display("FAIL t6_flip_addr: got %0d expected 111", rom_addr); end
        tick();
`endif
    endtask

    task automatic test_random_pixels();
        logic [15:0] p_color;
        logic        p_opq;
        bit          have_prev;
        int          c, r;
        for (int s = 0; s < 6; s++) begin
            anim_base = 2'($urandom_range(0, 3));
            posx = 10'($urandom_range(0, 1023));
            posy = 9'($urandom_range(0, 511));
`ifdef SPRITE_HFLIP_EN
            hflip = 1'($urandom_range(0, 1));
`endif
            tick();
            have_prev = 1'b0;
            for (int i = 0; i < 40; i++) begin
                c = m_px - 10 + int'($urandom_range(0, WIDTH + 20));
                r = m_py - 5 + int'($urandom_range(0, HEIGHT + 10));
                if (c < 0) c = 0;
                if (c > 1023) c = 1023;
                if (r < 0) r = 0;
                if (r > 511) r = 511;
                drive_pixel(c, r);
                checks++; if (rom_addr !== 15'(e_addr)) begin errors++; $display("FAIL rnd_addr s%0d i%0d: got %0d expected %0d", s, i, rom_addr, e_addr); end
                if (have_prev) begin
                    checks++; if (color !== p_color) begin errors++; $display("FAIL rnd_color s%0d i%0d: got %h expected %h", s, i, color, p_color); end
                    checks++; if (opaque !== p_opq) begin errors++; $display("FAIL rnd_opaque s%0d i%0d: got %b expected %b", s, i, opaque, p_opq); end
                end
                p_color = e_color; p_opq = e_opq; have_prev = 1'b1;
            end
            cycle();
            checks++; if (color !== p_color) begin errors++; $display("FAIL rnd_color_last s%0d: got %h expected %h", s, color, p_color); end
        end
`ifdef SPRITE_HFLIP_EN
        hflip = 1'b0;
        tick();
`endif
    endtask

    task automatic test_random_anim();
        int b;
        for (int s = 0; s < 8; s++) begin
            anim_mode = 2'($urandom_range(0, 3));
            b = int'($urandom_range(0, 3));
            anim_base = 2'(b);
            anim_len = 2'($urandom_range(0, 3 - b));
            anim_start = 1'b1;
            cycle();
            anim_start = 1'b0;
            for (int i = 0; i < 30; i++) begin
                frame_tick = ($urandom_range(0, 2) == 0);
                anim_start = ($urandom_range(0, 24) == 0);
                cycle();
                frame_tick = 1'b0;
                anim_start = 1'b0;
                $display("anim seg=%0d cyc=%0d mode=%0d frame=%0d done=%b", s, i, anim_mode, cur_frame, anim_done);
                checks++; if (cur_frame !== exp_frame2()) begin errors++; $display("FAIL anim_frame s%0d c%0d: got %0d expected %0d", s, i, cur_frame, exp_frame()); end
                checks++; if (anim_done !== exp_done()) begin errors++; $display("FAIL anim_done s%0d c%0d: got %b expected %b", s, i, anim_done, exp_done()); end
            end
        end
        anim_mode = 2'b00; anim_base = 2'd0;
        cycle();
    endtask

    task automatic test_reset_midline();
        logic [15:0] p_color;
        anim_mode = 2'b01; anim_base = 2'd0; anim_len = 2'd3; anim_start = 1'b1;
        cycle();
        anim_start = 1'b0;
        repeat (3) tick();
        posx = 10'd300; posy = 9'd20;
        tick();
        drive_pixel(310, 30);
        drive_pixel(311, 30);
        rst = 1'b1;
        #1;
        checks++; if (rom_addr !== 15'd0) begin errors++; $display("FAIL mid_rst_addr: got %0d expected 0", rom_addr); end
        checks++; if (color !== TRANSP) begin errors++; $display("FAIL mid_rst_color: got %h expected %h", color, TRANSP); end
        checks++; if (opaque !== 1'b0) begin errors++; $display("FAIL mid_rst_opaque: got %b expected 0", opaque); end
        checks++; if (cur_frame !== 2'd0) begin errors++; $display("FAIL mid_rst_frame: got %0d expected 0", cur_frame); end
        anim_mode = 2'b00; anim_base = 2'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        drive_pixel(5, 5);
        checks++; if (rom_addr !== 15'd565) begin errors++; $display("FAIL post_rst_box_addr: got %0d expected 565", rom_addr); end
        p_color = e_color;
        cycle();
        checks++; if (color !== p_color) begin errors++; $display("FAIL post_rst_color: got %h expected %h", color, p_color); end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin
            rom_mem[i] = (i % 7 == 3) ? TRANSP : 16'($urandom);
        end
        test_reset();
        test_latency_addr();
        test_clipping();
        test_loop();
        test_oneshot();
        test_tearing();
        test_random_pixels();
        test_random_anim();
        test_reset_midline();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
